// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: FSM encoding and default sizing.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  localparam int GNT_W = $clog2(DEF_NUM_REQ);
  localparam int CNT_W = $clog2(DEF_MAX_BURST + 1);

  // Width helper that never returns zero, so 1-entry counts still get a bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Circular priority picker: lowest set request at or above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;

  // Low half holds only requests at/above the pointer; high half is the wrapped copy.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(rr_ptr));
    end
    dbl    = {req, req & hi_mask};
    winner = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) winner = W'((i >= N) ? (i - N) : i);
    end
    any_req = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [$clog2(NUM_REQ)-1:0]    GNT_ID,
  output logic                          BUSY
);

  localparam int GW = width_of(NUM_REQ);
  localparam int CW = width_of(MAX_BURST + 1);

  arb_state_t    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] gnt_id;
  logic [GW-1:0] pick;
  logic [CW-1:0] burst_cnt;
  logic          any_req;
  logic          in_grant;
  logic          req_g;
  logic          ack_w;
  logic          last_word;
  logic          release_g;

  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req     (REQ),
    .rr_ptr  (rr_ptr),
    .winner  (pick),
    .any_req (any_req)
  );

  // Valid/ready contract: REQ[i] is valid, ACK[i] is ready-and-taken in the same
  // cycle; the requester holds REQ/REQ_DATA/REQ_LAST stable until it sees ACK.
  assign in_grant  = (state == ST_GRANT);
  assign req_g     = REQ[gnt_id];
  assign ack_w     = in_grant & req_g & ~FULL;
  assign last_word = REQ_LAST[gnt_id] | (burst_cnt == CW'(MAX_BURST - 1));
  // A withdrawn requester is released even during a FULL stall.
  assign release_g = in_grant & (~req_g | (ack_w & last_word));

  assign W_INC   = ack_w;
  assign ACK     = NUM_REQ'(ack_w) << gnt_id;
  assign WR_DATA = in_grant ? REQ_DATA[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign GNT_ID  = gnt_id;
  assign BUSY    = in_grant;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt_id    <= pick;
            burst_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_g) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            rr_ptr    <= (gnt_id == GW'(NUM_REQ - 1)) ? '0 : gnt_id + GW'(1);
          end else if (ack_w) begin
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO among N write-domain requesters. It grants one requester at a time for a bounded burst and drives the FIFO write controls (W_INC, WR_DATA) from the granted requester's data. It respects the FIFO FULL flag and returns a per-requester ACK for every accepted word. It sits entirely in the FIFO write clock domain, directly in front of the FIFO write interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, FIFO word width
MAX_BURST, 4, maximum words accepted per grant before forced release (1..15)

Ports:
CLK  in  1  write-domain clock; all state updates on the rising edge
RST  in  1  asynchronous reset, active-high
REQ  in  NUM_REQ  request; bit i high means requester i has a valid word
REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed data; slice i is [i*DATA_WIDTH +: DATA_WIDTH]
REQ_LAST  in  NUM_REQ  marks the final word of requester i's burst
FULL  in  1  FIFO full flag, write-domain synchronous
W_INC  out  1  FIFO write enable
WR_DATA  out  DATA_WIDTH  FIFO write data
ACK  out  NUM_REQ  one-hot; word of requester i accepted this cycle
GNT_ID  out  clog2(NUM_REQ)  index of the current or last granted requester
BUSY  out  1  high while in GRANT

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, RR_PTR = 0, GNT_ID = 0, burst count = 0.
  - W_INC = 0, ACK = 0, BUSY = 0, WR_DATA = 0.
- States: IDLE, GRANT. Encoding is 1 bit.
- IDLE:
  - W_INC = 0 and ACK = 0.
  - If REQ is nonzero, select the first set bit searching circularly from RR_PTR upward.
  - On that edge, register GNT_ID = winner, clear burst count, go to GRANT.
  - Arbitration latency is 1 cycle from REQ to the first possible ACK.
- GRANT:
  - ACK[GNT_ID] = W_INC = REQ[GNT_ID] & ~FULL, combinationally. All other ACK bits are 0.
  - WR_DATA = REQ_DATA slice GNT_ID, combinationally and continuously while in GRANT. WR_DATA = 0 in IDLE.
  - Each ACK increments burst count.
  - Release condition (any one):
    - ACK with REQ_LAST[GNT_ID] = 1
    - ACK when burst count == MAX_BURST-1, i.e. the MAX_BURST-th word
    - REQ[GNT_ID] = 0 (requester withdrew)
  - On release: RR_PTR = (GNT_ID+1) mod NUM_REQ, next state IDLE, burst count cleared.
  - There is a one-cycle bubble between grants by design.
- FULL handling:
  - FULL high in GRANT gives no W_INC and no ACK.
  - Grant and burst count are held and the requester is not released. Stall is unbounded.
- Requester obligations:
  - REQ, REQ_DATA and REQ_LAST stay stable until ACK.
  - Data is consumed only on a cycle where ACK is high.
- Simultaneous events:
  - REQ_LAST together with the MAX_BURST-th word is a single release.
  - REQ_LAST while FULL is high is not a release; it is retried when FULL drops.
- Rotation: RR_PTR is updated only on release, so rotation is fair. A requester withdrawn mid-burst loses its turn.
- Reset mid-burst:
  - Immediate return to IDLE and RR_PTR = 0.
  - Words already ACKed stay in the FIFO. Unacked words must be reissued.
- GNT_ID holds its value in IDLE until the next arbitration.

Decomposition:
- Package fifo_arb_pkg:
  - state enum/localparams ST_IDLE = 1'b0, ST_GRANT = 1'b1
  - width constants: GNT_W = clog2(NUM_REQ), CNT_W = clog2(MAX_BURST+1)
  - default DATA_WIDTH
- Sub-module rr_pick: combinational circular priority picker.
  - Inputs: REQ, RR_PTR.
  - Outputs: winner index, any_req.
  - Implementation: double-width masked find-first.

Test Plan:
1. Single requester, fixed burst: NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4; only REQ[2] high, data 0xA0..0xA2, LAST on third word, FULL=0 -> GNT_ID=2 one cycle after REQ; ACK[2]/W_INC on 3 consecutive cycles; WR_DATA sequence A0, A1, A2; IDLE next; RR_PTR=3.
2. Round-robin fairness: REQ=4'b1111, each requester sends 1 word with LAST -> grant order 0, 1, 2, 3, 0; one idle bubble between grants.
3. Burst cap: REQ[1] continuous with LAST never asserted -> exactly 4 ACKs, then release; requester 1 regranted only after the others (REQ[3] also high, so 3 is granted next).
4. FULL stall: grant to 0; FULL high for 5 cycles after the first ACK -> W_INC=0, ACK=0, GNT_ID held at 0, BUSY=1; on FULL low, the second word is written; burst count resumes at 1.
5. Withdrawal and priority wrap: requester 3 drops REQ after 1 word; REQ=4'b0011 -> release; RR_PTR wraps to 0; grant to 0.
6. Asynchronous reset mid-burst: RST pulsed between clock edges during the second word of a burst -> W_INC, ACK and BUSY go low immediately; after release, REQ=4'b0100 gives GNT_ID=2 with RR_PTR reset to 0.
